// File: rtl/cache_arb_pkg.sv
// cache_arb_pkg: shared types for the two-port cache arbiter.
// FSM state encoding and requester port indices.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } arb_state_e;

  localparam logic PORT_IFETCH = 1'b0;
  localparam logic PORT_DATA   = 1'b1;

endpackage

// File: rtl/cache_arbiter_rr_pick2.sv
// rr_pick2: combinational 2-way round-robin chooser.
// req0/req1 + last grant in -> gnt_valid, gnt_idx out.
module rr_pick2
  import cache_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt_valid,
  output logic gnt_idx
);

  always_comb begin
    gnt_valid = req0 | req1;
    gnt_idx   = PORT_IFETCH;
    unique case (1'b1)
      (req0 && req1):  gnt_idx = ~last;
      (req1 && !req0): gnt_idx = PORT_DATA;
      (req0 && !req1): gnt_idx = PORT_IFETCH;
      default:         gnt_idx = PORT_IFETCH;
    endcase
  end

endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one Cache port between ifetch (0) and data (1).
// Ports: sys_clk, rst_n (sync, active-low); req/addr/wdata/we per
// requester; ack0/ack1, err, rdata back; cache_* to/from the Cache.
module cache_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              we0,
  input  logic              we1,
  output logic              ack0,
  output logic              ack1,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] cache_address,
  output logic [DATA_W-1:0] cache_data_in,
  output logic              cache_write_enable,
  input  logic [DATA_W-1:0] cache_data_out,
  input  logic              cache_data_out_valid
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT - 1);

  arb_state_e        state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] din_d;
  logic              we_d;
  logic [DATA_W-1:0] rdata_d;
  logic              err_d;
  logic              ack0_d, ack1_d;
  logic              pick_valid, pick_idx;

  rr_pick2 u_pick (
    .req0      (req0),
    .req1      (req1),
    .last      (last_q),
    .gnt_valid (pick_valid),
    .gnt_idx   (pick_idx)
  );

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q            <= IDLE;
      gnt_q              <= PORT_IFETCH;
      last_q             <= PORT_DATA;
      cnt_q              <= '0;
      cache_address      <= '0;
      cache_data_in      <= '0;
      cache_write_enable <= 1'b0;
      rdata              <= '0;
      err                <= 1'b0;
      ack0               <= 1'b0;
      ack1               <= 1'b0;
    end else begin
      state_q            <= state_d;
      gnt_q              <= gnt_d;
      last_q             <= last_d;
      cnt_q              <= cnt_d;
      cache_address      <= addr_d;
      cache_data_in      <= din_d;
      cache_write_enable <= we_d;
      rdata              <= rdata_d;
      err                <= err_d;
      ack0               <= ack0_d;
      ack1               <= ack1_d;
    end
  end

  // ack is registered on the WAIT->ACK edge so that it is
  // high exactly during the ACK state.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    addr_d  = cache_address;
    din_d   = cache_data_in;
    we_d    = cache_write_enable;
    rdata_d = rdata;
    err_d   = err;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        we_d = 1'b0;
        if (pick_valid) begin
          gnt_d   = pick_idx;
          last_d  = pick_idx;
          addr_d  = pick_idx ? addr1 : addr0;
          din_d   = pick_idx ? wdata1 : wdata0;
          we_d    = pick_idx ? we1 : we0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // valid still reflects the previous address here
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (cache_data_out_valid) begin
          rdata_d = cache_data_out;
          err_d   = 1'b0;
          we_d    = 1'b0;
          ack0_d  = (gnt_q == PORT_IFETCH);
          ack1_d  = (gnt_q == PORT_DATA);
          state_d = ACK;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          we_d    = 1'b0;
          ack0_d  = (gnt_q == PORT_IFETCH);
          ack1_d  = (gnt_q == PORT_DATA);
          state_d = ACK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed + random checks of cache_arbiter
// against a transaction-level timing model.
module tb_cache_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          sys_clk = 1'b0;
  logic          rst_n;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, err;
  logic [DW-1:0] rdata;
  logic [AW-1:0] cache_address;
  logic [DW-1:0] cache_data_in;
  logic          cache_write_enable;
  logic [DW-1:0] cache_data_out;
  logic          cache_data_out_valid;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  cache_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TO)
  ) dut (
    .sys_clk              (sys_clk),
    .rst_n                (rst_n),
    .req0                 (req0),
    .req1                 (req1),
    .addr0                (addr0),
    .addr1                (addr1),
    .wdata0               (wdata0),
    .wdata1               (wdata1),
    .we0                  (we0),
    .we1                  (we1),
    .ack0                 (ack0),
    .ack1                 (ack1),
    .err                  (err),
    .rdata                (rdata),
    .cache_address        (cache_address),
    .cache_data_in        (cache_data_in),
    .cache_write_enable   (cache_write_enable),
    .cache_data_out       (cache_data_out),
    .cache_data_out_valid (cache_data_out_valid)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h",
               nm, cyc, act, exp);
    end
  endtask

  // Transaction model: a grant at cycle g may complete at
  // the first cycle c in [g+2, g+TO+1] where valid is seen,
  // ack at c+1; otherwise it times out and acks at g+TO+2.
  logic          m_busy = 1'b0;
  logic          m_last = 1'b1;
  logic          m_win = 1'b0;
  int            m_g = 0;
  int            m_ackc = -1;
  logic          m_ack0 = 1'b0, m_ack1 = 1'b0;
  logic          m_err = 1'b0, m_we = 1'b0;
  logic [DW-1:0] m_rdata = '0, m_din = '0;
  logic [AW-1:0] m_addr = '0;

  task automatic finish_txn(logic [DW-1:0] d, logic e);
    m_rdata = d;
    m_err   = e;
    m_we    = 1'b0;
    m_ack0  = (m_win == 1'b0);
    m_ack1  = (m_win == 1'b1);
    m_busy  = 1'b0;
    m_ackc  = cyc + 1;
  endtask

  task automatic model_step();
    m_ack0 = 1'b0;
    m_ack1 = 1'b0;
    if (!rst_n) begin
      m_busy  = 1'b0;
      m_last  = 1'b1;
      m_ackc  = -1;
      m_addr  = '0;
      m_din   = '0;
      m_we    = 1'b0;
      m_rdata = '0;
      m_err   = 1'b0;
    end else if (m_busy) begin
      if (cyc >= m_g + 2) begin
        if (cache_data_out_valid)
          finish_txn(cache_data_out, 1'b0);
        else if (cyc == m_g + TO + 1)
          finish_txn('0, 1'b1);
      end
    end else if (cyc != m_ackc && (req0 || req1)) begin
      m_win  = (req0 && req1) ? !m_last : req1;
      m_last = m_win;
      m_g    = cyc;
      m_busy = 1'b1;
      m_addr = m_win ? addr1 : addr0;
      m_din  = m_win ? wdata1 : wdata0;
      m_we   = m_win ? we1 : we0;
    end
  endtask

  always @(negedge sys_clk) begin
    chk("ack0", ack0, m_ack0);
    chk("ack1", ack1, m_ack1);
    chk("err", err, m_err);
    chk("rdata", rdata, m_rdata);
    chk("cache_address", cache_address, m_addr);
    chk("cache_data_in", cache_data_in, m_din);
    chk("cache_we", cache_write_enable, m_we);
    model_step();
    cyc++;
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic quiet();
    req0 = 1'b0;
    req1 = 1'b0;
    we0  = 1'b0;
    we1  = 1'b0;
    cache_data_out_valid = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    quiet();
    addr0  = '0;
    addr1  = '0;
    wdata0 = '0;
    wdata1 = '0;
    cache_data_out = '0;
    tick();
    tick();
    rst_n = 1'b1;

    // reset state
    @(negedge sys_clk);
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_addr", cache_address, 0);
    chk("rst_we", cache_write_enable, 0);
    tick();

    // single read on port 0
    req0 = 1'b1;
    addr0 = 32'h10;
    wdata0 = 32'h1111;
    cache_data_out_valid = 1'b1;
    cache_data_out = 32'h12345678;
    for (int k = 0; k < 4; k++) begin
      @(negedge sys_clk);
      chk("rd_ack1", ack1, 0);
      chk("rd_ack0", ack0, (k == 3));
      if (k == 1) chk("rd_addr", cache_address, 32'h10);
    end
    chk("rd_rdata", rdata, 32'h12345678);
    chk("rd_err", err, 0);
    tick();
    quiet();
    tick();

    // single write on port 1
    req1 = 1'b1;
    we1 = 1'b1;
    addr1 = 32'h20;
    wdata1 = 32'hDEADBEEF;
    cache_data_out_valid = 1'b1;
    cache_data_out = 32'hCAFE0001;
    for (int k = 0; k < 4; k++) begin
      @(negedge sys_clk);
      chk("wr_we", cache_write_enable, (k == 1 || k == 2));
      chk("wr_ack1", ack1, (k == 3));
      chk("wr_ack0", ack0, 0);
    end
    chk("wr_din", cache_data_in, 32'hDEADBEEF);
    chk("wr_addr", cache_address, 32'h20);
    tick();
    quiet();
    tick();

    // both held: alternate 0,1,0,1 every 4 cycles
    do_reset();
    req0 = 1'b1;
    req1 = 1'b1;
    cache_data_out_valid = 1'b1;
    cache_data_out = 32'hA5A5A5A5;
    for (int k = 0; k < 32; k++) begin
      @(negedge sys_clk);
      chk("rr_ack0", ack0, (k % 4 == 3) && ((k / 4) % 2 == 0));
      chk("rr_ack1", ack1, (k % 4 == 3) && ((k / 4) % 2 == 1));
      if (k < 31) tick();
    end
    tick();
    quiet();
    tick();
    tick();
    tick();

    // timeout: ack at grant+TO+2 with err
    req0 = 1'b1;
    we0 = 1'b1;
    addr0 = 32'h30;
    wdata0 = 32'h55;
    for (int k = 0; k <= TO + 2; k++) begin
      @(negedge sys_clk);
      chk("to_we", cache_write_enable, (k >= 1 && k <= TO + 1));
      chk("to_ack0", ack0, (k == TO + 2));
      if (k < TO + 2) tick();
    end
    chk("to_err", err, 1);
    chk("to_rdata", rdata, 0);
    tick();
    quiet();
    tick();

    // addr change during WAIT; no re-grant in ACK
    req0 = 1'b1;
    addr0 = 32'h40;
    tick();
    tick();
    addr0 = 32'h44;
    tick();
    cache_data_out_valid = 1'b1;
    cache_data_out = 32'h0BADF00D;
    @(negedge sys_clk);
    chk("chg_addr", cache_address, 32'h40);
    tick();
    @(negedge sys_clk);
    chk("chg_ack0", ack0, 1);
    tick();
    @(negedge sys_clk);
    chk("noregrant_addr", cache_address, 32'h40);
    tick();
    req0 = 1'b0;
    @(negedge sys_clk);
    chk("regrant_addr", cache_address, 32'h44);
    tick();
    tick();
    @(negedge sys_clk);
    chk("drop_ack0", ack0, 1);
    tick();
    quiet();
    tick();

    // reset mid-WAIT with req0 held
    req0 = 1'b1;
    we0 = 1'b1;
    addr0 = 32'h50;
    wdata0 = 32'h77;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    cache_data_out_valid = 1'b1;
    @(negedge sys_clk);
    chk("mr_addr", cache_address, 0);
    chk("mr_din", cache_data_in, 0);
    chk("mr_we", cache_write_enable, 0);
    chk("mr_rdata", rdata, 0);
    chk("mr_ack0", ack0, 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      @(negedge sys_clk);
      chk("mr_ack0_after", ack0, (k == 3));
    end
    tick();
    quiet();
    tick();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if (!req0) req0 = 1'($urandom_range(0, 1));
      else if ($urandom_range(0, 15) == 0) req0 = 1'b0;
      if (!req1) req1 = 1'($urandom_range(0, 1));
      else if ($urandom_range(0, 15) == 0) req1 = 1'b0;
      addr0  = $urandom;
      addr1  = $urandom;
      wdata0 = $urandom;
      wdata1 = $urandom;
      we0    = 1'($urandom_range(0, 1));
      we1    = 1'($urandom_range(0, 1));
      cache_data_out_valid = ($urandom_range(0, 3) == 0);
      cache_data_out = $urandom;
      tick();
    end
    rst_n = 1'b1;
    quiet();
    repeat (12) tick();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
